// File: rtl/agc_pkg.sv
// ============================================================================
// agc_pkg : shared state encoding and Q8.8 RSSI types for the RSSI AGC loop
// Rev 1.0
// ============================================================================
`default_nettype none

package agc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FROZEN  = 3'd4
  } agc_state_e;

  typedef logic signed [15:0] db_q8_t;

  localparam db_q8_t DB_Q8_MIN = 16'sh8000;

endpackage

`default_nettype wire

// File: rtl/agc_dwell_det.sv
// ============================================================================
// agc_dwell_det : window/coarse classification and dwell run counting
// Rev 1.0
// ============================================================================
`default_nettype none

module agc_dwell_det
  import agc_pkg::*;
#(
  parameter int P_TARGET_Q8 = 15360,
  parameter int P_WINDOW_Q8 = 768,
  parameter int P_COARSE_Q8 = 3072,
  parameter int P_DWELL     = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_clr,
  input  logic   i_vld,
  input  db_q8_t i_rssi,
  output logic   o_step_dn,
  output logic   o_step_up,
  output logic   o_coarse,
  output logic   o_in_win_done
);

  localparam int CW = $clog2(P_DWELL + 1);
  localparam logic [CW-1:0]     c_last = CW'(P_DWELL - 1);
  localparam logic signed [17:0] c_hi   = 18'(P_TARGET_Q8 + P_WINDOW_Q8);
  localparam logic signed [17:0] c_lo   = 18'(P_TARGET_Q8 - P_WINDOW_Q8);
  localparam logic signed [17:0] c_hi_c = 18'(P_TARGET_Q8 + P_WINDOW_Q8 + P_COARSE_Q8);
  localparam logic signed [17:0] c_lo_c = 18'(P_TARGET_Q8 - P_WINDOW_Q8 - P_COARSE_Q8);

  logic [CW-1:0]      r_hi_cnt, r_lo_cnt, r_in_cnt;
  logic               r_coarse;
  logic signed [17:0] w_x;
  logic               w_is_hi, w_is_lo, w_is_in, w_same, w_coarse;
  logic               w_hi_done, w_lo_done, w_in_done, w_any_done;

  assign w_x       = {{2{i_rssi[15]}}, i_rssi};
  assign w_is_hi   = w_x > c_hi;
  assign w_is_lo   = w_x < c_lo;
  assign w_is_in   = !w_is_hi && !w_is_lo;
  // The coarse flag only survives while the current run keeps the same direction.
  assign w_same    = w_is_hi ? (r_hi_cnt != '0) : (w_is_lo ? (r_lo_cnt != '0) : 1'b0);
  assign w_coarse  = (w_same & r_coarse) | (w_x > c_hi_c) | (w_x < c_lo_c);

  assign w_hi_done  = i_vld && w_is_hi && (r_hi_cnt == c_last);
  assign w_lo_done  = i_vld && w_is_lo && (r_lo_cnt == c_last);
  assign w_in_done  = i_vld && w_is_in && (r_in_cnt == c_last);
  assign w_any_done = w_hi_done || w_lo_done || w_in_done;

  assign o_step_dn     = w_hi_done;
  assign o_step_up     = w_lo_done;
  assign o_coarse      = w_coarse;
  assign o_in_win_done = w_in_done;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
      r_in_cnt <= '0;
      r_coarse <= 1'b0;
    end else if (i_vld) begin
      if (w_any_done) begin
        r_hi_cnt <= '0;
        r_lo_cnt <= '0;
        r_in_cnt <= '0;
        r_coarse <= 1'b0;
      end else begin
        r_hi_cnt <= w_is_hi ? r_hi_cnt + 1'b1 : '0;
        r_lo_cnt <= w_is_lo ? r_lo_cnt + 1'b1 : '0;
        r_in_cnt <= w_is_in ? r_in_cnt + 1'b1 : '0;
        r_coarse <= w_coarse;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rssi_agc_ctrl.sv
// ============================================================================
// rssi_agc_ctrl : RSSI-driven gain stepping FSM with settle, lock and freeze
// Optional peak-hold register enabled by AGC_PEAK_HOLD_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module rssi_agc_ctrl
  import agc_pkg::*;
#(
  parameter int P_GAIN_W    = 4,
  parameter int P_GAIN_INIT = 15,
  parameter int P_TARGET_Q8 = 15360,
  parameter int P_WINDOW_Q8 = 768,
  parameter int P_COARSE_Q8 = 3072,
  parameter int P_DWELL     = 4,
  parameter int P_SETTLE    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rssi_vld,
  input  db_q8_t              i_rssi_q8,
  input  logic                i_freeze,
  input  logic                i_restart,
  output logic [P_GAIN_W-1:0] o_gain_idx,
  output logic                o_gain_upd,
  output logic                o_locked,
  output logic [2:0]          o_state,
  output db_q8_t              o_rssi_peak_q8
);

  localparam int SW = $clog2(P_SETTLE + 1);
  localparam logic [SW-1:0]       c_settle_last = SW'(P_SETTLE - 1);
  localparam logic [P_GAIN_W-1:0] c_init        = P_GAIN_W'(P_GAIN_INIT);
  localparam logic [P_GAIN_W:0]   c_init_x      = (P_GAIN_W + 1)'(P_GAIN_INIT);

  agc_state_e          r_state, w_nxt_state;
  logic [P_GAIN_W-1:0] r_gain, w_nxt_gain;
  logic                r_upd, w_nxt_upd;
  logic                r_locked, w_nxt_locked;
  logic [SW-1:0]       r_settle, w_nxt_settle;
  logic                w_clr, w_smp;
  logic                w_step_dn, w_step_up, w_coarse, w_in_done;
  logic [P_GAIN_W:0]   w_step, w_sum, w_gain_dn, w_gain_up;

  agc_dwell_det #(
    .P_TARGET_Q8 (P_TARGET_Q8),
    .P_WINDOW_Q8 (P_WINDOW_Q8),
    .P_COARSE_Q8 (P_COARSE_Q8),
    .P_DWELL     (P_DWELL)
  ) u_dwell (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (w_clr),
    .i_vld         (w_smp),
    .i_rssi        (i_rssi_q8),
    .o_step_dn     (w_step_dn),
    .o_step_up     (w_step_up),
    .o_coarse      (w_coarse),
    .o_in_win_done (w_in_done)
  );

  // Saturating +/- step, computed one bit wider so the add cannot wrap.
  assign w_step    = w_coarse ? (P_GAIN_W + 1)'(2) : (P_GAIN_W + 1)'(1);
  assign w_sum     = {1'b0, r_gain} + w_step;
  assign w_gain_up = (w_sum > c_init_x) ? c_init_x : w_sum;
  assign w_gain_dn = ({1'b0, r_gain} < w_step) ? '0 : ({1'b0, r_gain} - w_step);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_gain   = r_gain;
    w_nxt_upd    = 1'b0;
    w_nxt_locked = r_locked;
    w_nxt_settle = r_settle;
    w_clr        = 1'b0;
    w_smp        = 1'b0;
    if (i_restart) begin
      w_nxt_gain   = c_init;
      w_nxt_upd    = (r_gain != c_init);
      w_nxt_state  = SETTLE;
      w_nxt_locked = 1'b0;
      w_nxt_settle = '0;
      w_clr        = 1'b1;
    end else if (i_freeze) begin
      if (r_state != IDLE) w_nxt_state = FROZEN;
    end else begin
      case (r_state)
        IDLE: if (i_rssi_vld) w_nxt_state = SETTLE;
        SETTLE: begin
          if (i_rssi_vld) begin
            if (r_settle == c_settle_last) begin
              w_nxt_state  = MEASURE;
              w_nxt_settle = '0;
              w_clr        = 1'b1;
            end else begin
              w_nxt_settle = r_settle + 1'b1;
            end
          end
        end
        MEASURE, LOCKED: begin
          w_smp = i_rssi_vld;
          if (w_step_dn || w_step_up) begin
            w_nxt_gain = w_step_dn ? w_gain_dn[P_GAIN_W-1:0] : w_gain_up[P_GAIN_W-1:0];
            if (w_nxt_gain != r_gain) begin
              w_nxt_upd    = 1'b1;
              w_nxt_state  = SETTLE;
              w_nxt_locked = 1'b0;
              w_nxt_settle = '0;
            end
          end else if (w_in_done && r_state == MEASURE) begin
            w_nxt_state  = LOCKED;
            w_nxt_locked = 1'b1;
          end
        end
        FROZEN: begin
          w_nxt_state = r_locked ? LOCKED : MEASURE;
          w_clr       = 1'b1;
        end
        default: w_nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_gain   <= c_init;
      r_upd    <= 1'b0;
      r_locked <= 1'b0;
      r_settle <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_gain   <= w_nxt_gain;
      r_upd    <= w_nxt_upd;
      r_locked <= w_nxt_locked;
      r_settle <= w_nxt_settle;
    end
  end

`ifdef AGC_PEAK_HOLD_EN
  db_q8_t r_peak;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || w_nxt_upd) begin
      r_peak <= DB_Q8_MIN;
    end else if (w_smp && (i_rssi_q8 > r_peak)) begin
      r_peak <= i_rssi_q8;
    end
  end

  assign o_rssi_peak_q8 = r_peak;
`else
  assign o_rssi_peak_q8 = 16'sh0000;
`endif

  assign o_gain_idx = r_gain;
  assign o_gain_upd = r_upd;
  assign o_locked   = r_locked;
  assign o_state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rssi_agc_ctrl.sv
// ============================================================================
// tb_rssi_agc_ctrl : directed + random stimulus scored against a sample-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rssi_agc_ctrl;

  localparam int GMAX   = 15;
  localparam int HI     = 15360 + 768;
  localparam int LO     = 15360 - 768;
  localparam int HI_C   = HI + 3072;
  localparam int LO_C   = LO - 3072;
  localparam int PMIN   = -32768;

  typedef struct {
    int gain;
    int upd;
    int locked;
    int state;
    int peak;
  } exp_t;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_rssi_vld = 1'b0;
  logic signed [15:0] i_rssi_q8 = '0;
  logic               i_freeze = 1'b0;
  logic               i_restart = 1'b0;
  logic [3:0]         o_gain_idx;
  logic               o_gain_upd;
  logic               o_locked;
  logic [2:0]         o_state;
  logic signed [15:0] o_rssi_peak_q8;

  rssi_agc_ctrl dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_rssi_vld     (i_rssi_vld),
    .i_rssi_q8      (i_rssi_q8),
    .i_freeze       (i_freeze),
    .i_restart      (i_restart),
    .o_gain_idx     (o_gain_idx),
    .o_gain_upd     (o_gain_upd),
    .o_locked       (o_locked),
    .o_state        (o_state),
    .o_rssi_peak_q8 (o_rssi_peak_q8)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: state as plain ints, dwell tracked as "current run" of samples.
  int m_state, m_gain, m_upd, m_locked, m_peak, m_settled;
  int run_kind, run_len, run_coarse;

  task automatic model(input bit rst, input bit vld, input int x, input bit frz, input bit rs);
    int kind, crs, stp, ng;
    m_upd = 0;
    if (rst) begin
      m_state = 0; m_gain = GMAX; m_locked = 0; m_peak = PMIN; m_settled = 0;
      run_kind = 99; run_len = 0; run_coarse = 0;
    end else if (rs) begin
      m_upd = (m_gain != GMAX);
      m_gain = GMAX; m_state = 1; m_locked = 0; m_settled = 0; m_peak = PMIN;
      run_kind = 99; run_len = 0;
    end else if (frz) begin
      if (m_state != 0) m_state = 4;
    end else begin
      case (m_state)
        0: if (vld) m_state = 1;
        1: if (vld) begin
          m_settled++;
          if (m_settled == 32) begin
            m_state = 2; m_settled = 0; run_kind = 99; run_len = 0;
          end
        end
        2, 3: if (vld) begin
          if (x > m_peak) m_peak = x;
          kind = (x > HI) ? 1 : ((x < LO) ? -1 : 0);
          crs  = (x > HI_C || x < LO_C) ? 1 : 0;
          if (kind == run_kind) begin
            run_len++; run_coarse = run_coarse | crs;
          end else begin
            run_kind = kind; run_len = 1; run_coarse = crs;
          end
          if (run_len == 4) begin
            stp = run_coarse ? 2 : 1;
            run_kind = 99; run_len = 0;
            if (kind == 0) begin
              if (m_state == 2) begin m_state = 3; m_locked = 1; end
            end else begin
              ng = (kind == 1) ? m_gain - stp : m_gain + stp;
              if (ng < 0) ng = 0;
              if (ng > GMAX) ng = GMAX;
              if (ng != m_gain) begin
                m_gain = ng; m_upd = 1; m_state = 1; m_locked = 0;
                m_settled = 0; m_peak = PMIN;
              end
            end
          end
        end
        4: begin
          m_state = m_locked ? 3 : 2; run_kind = 99; run_len = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input int x, input bit frz, input bit rs);
    exp_t e;
    @(negedge clk);
    i_rst = rst; i_rssi_vld = vld; i_rssi_q8 = 16'(x); i_freeze = frz; i_restart = rs;
    model(rst, vld, x, frz, rs);
    e.gain = m_gain; e.upd = m_upd; e.locked = m_locked; e.state = m_state;
`ifdef AGC_PEAK_HOLD_EN
    e.peak = m_peak;
`else
    e.peak = 0;
`endif
    q.push_back(e);
  endtask

  task automatic samples(input int n, input int x);
    for (int i = 0; i < n; i++) drive(0, 1, x, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("gain_idx", int'(o_gain_idx), e.gain);
        chk("gain_upd", int'(o_gain_upd), e.upd);
        chk("locked", int'(o_locked), e.locked);
        chk("state", int'(o_state), e.state);
        chk("peak", int'($signed(o_rssi_peak_q8)), e.peak);
      end
    end
  end

  function automatic int pick(input int k);
    int bnd[8];
    bnd = '{HI, HI + 1, LO, LO - 1, HI_C, HI_C + 1, LO_C, LO_C - 1};
    case (k)
      0: return int'($urandom_range(LO, HI));
      1: return int'($urandom_range(HI + 1, HI_C));
      2: return int'($urandom_range(HI_C + 1, 32767));
      3: return int'($urandom_range(LO_C, LO - 1));
      4: return int'($urandom_range(0, LO_C - 1 + 32768)) - 32768;
      default: return bnd[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin : stim
    bit frz;
    int k, len;
    repeat (3) drive(1, 0, 0, 0, 0);
    samples(40, 15360);                       // settle then lock, gain stays 15
    samples(4, 17408);                        // one fine step down
    for (int r = 0; r < 9; r++) begin         // coarse steps to 0, then saturated runs
      samples(32, 15360);
      samples(4, 23552);
    end
    samples(4, 5000);                         // climb back: 0 -> 2 -> 3 -> 4 -> 5
    samples(32, 15360); samples(4, 14000);
    samples(32, 15360); samples(4, 14000);
    samples(32, 15360); samples(4, 14000);
    samples(32, 15360); samples(2, 15360);    // in MEASURE
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    samples(3, 15360);
    drive(0, 1, 15360, 1, 1);                 // restart wins over freeze
    samples(10, 15360);
    drive(1, 1, 15360, 0, 0);                 // reset mid-settle
    drive(0, 0, 0, 0, 0);
    samples(33, 15360);
    drive(0, 1, 15000, 0, 0); drive(0, 1, 15600, 0, 0); drive(0, 1, 15200, 0, 0);
    samples(4, 17408);
    samples(2, 15360);
    frz = 0;
    for (int b = 0; b < 600; b++) begin
      k   = $urandom_range(0, 5);
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 19) == 0) frz = !frz;
      for (int i = 0; i < len; i++)
        drive($urandom_range(0, 799) == 0, $urandom_range(0, 3) != 0, pick(k), frz,
              $urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) samples(32, pick(0));
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
